count_seq_ctrl: RTL and testbench

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

---
 rtl/count_seq_ctrl.sv | 84 ++++++++
 tb/tb_count_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - terminal-count sequencer with one-shot/auto-reload modes, pause and wrap counting
module count_seq_ctrl #(
    parameter int W      = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              reload,
    input  logic [W-1:0]      term,
    output logic [W-1:0]      count,
    output logic              done,
    output logic              busy,
    output logic [1:0]        state,
    output logic [WRAP_W-1:0] wraps
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [WRAP_W-1:0] WRAPS_MAX = {WRAP_W{1'b1}};

    logic [1:0]   state_q;
    logic [W-1:0] term_q;

    // stop outranks everything, including a simultaneous start or a terminal edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count   <= '0;
            term_q  <= '0;
            done    <= 1'b0;
            wraps   <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state_q <= S_IDLE;
                count   <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state_q <= S_RUN;
                            count   <= '0;
                            term_q  <= term;
                            wraps   <= '0;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            state_q <= S_PAUSE;
                        end else if (count == term_q) begin
                            count   <= '0;
                            done    <= 1'b1;
                            state_q <= reload ? S_RUN : S_DONE;
                            if (wraps != WRAPS_MAX) begin
                                wraps <= wraps + 1'b1;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        // the release edge only resumes; the next increment happens one edge later
                        if (!pause) begin
                            state_q <= S_RUN;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign state = state_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - randomized and directed bench for count_seq_ctrl
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       reload = 1'b0;
    logic [3:0] term = 4'd0;
    logic [3:0] count;
    logic       done;
    logic       busy;
    logic [1:0] state;
    logic [7:0] wraps;

    int errors = 0;
    int checks = 0;

    count_seq_ctrl #(.W(4), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .reload(reload), .term(term), .count(count), .done(done), .busy(busy),
        .state(state), .wraps(wraps)
    );

    always #5 clk = ~clk;

    // Reference: a run is a number of unpaused RUN steps; count is that number
    // modulo the period term+1 and every completed period is one terminal event.
    int m_mode;     // 0 idle, 1 run, 2 pause, 3 done
    int m_steps;
    int m_events;
    int m_term;
    bit m_done;

    function automatic void model_reset();
        m_mode = 0; m_steps = 0; m_events = 0; m_term = 0; m_done = 0;
    endfunction

    function automatic void model_step();
        m_done = 0;
        if (stop) begin
            m_mode = 0;
            m_steps = 0;
        end else if ((m_mode == 0 || m_mode == 3) && start) begin
            m_mode = 1; m_steps = 0; m_events = 0; m_term = int'(term);
        end else if (m_mode == 1 && pause) begin
            m_mode = 2;
        end else if (m_mode == 1) begin
            m_steps++;
            if (m_steps % (m_term + 1) == 0) begin
                m_events++;
                m_done = 1;
                if (!reload) m_mode = 3;
            end
        end else if (m_mode == 2 && !pause) begin
            m_mode = 1;
        end
    endfunction

    function automatic int exp_count();
        return (m_mode == 1 || m_mode == 2) ? m_steps % (m_term + 1) : 0;
    endfunction

    function automatic int exp_wraps();
        return (m_events > 255) ? 255 : m_events;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0d exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        checks++; if (wraps !== 8'd0) begin errors++; $display("FAIL reset_wraps got=%0d exp=0", wraps); end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        start = 1'b1; term = 4'd3;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL first_start_state got=%0d exp=1", state); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_one_shot();
        int exp_c[4] = '{1, 2, 3, 0};
        term = 4'd3; reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (count !== 4'd0 || state !== 2'b01) begin errors++; $display("FAIL oneshot_start count=%0d state=%0d exp 0/1", count, state); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (count !== exp_c[i][3:0]) begin errors++; $display("FAIL oneshot_count i=%0d got=%0d exp=%0d", i, count, exp_c[i]); end
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL oneshot_done i=%0d got=%0d exp=%0d", i, done, (i == 3)); end
        end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL oneshot_state got=%0d exp=3", state); end
        checks++; if (wraps !== 8'd1) begin errors++; $display("FAIL oneshot_wraps got=%0d exp=1", wraps); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy got=%0d exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0 || state !== 2'b11 || count !== 4'd0 || wraps !== 8'd1) begin
            errors++; $display("FAIL oneshot_hold done=%0d state=%0d count=%0d wraps=%0d exp 0/3/0/1", done, state, count, wraps);
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_auto_reload();
        int dn = 0;
        term = 4'd2; reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done) dn++;
            checks++; if (count !== 4'((i + 1) % 3)) begin errors++; $display("FAIL reload_count i=%0d got=%0d exp=%0d", i, count, (i + 1) % 3); end
        end
        checks++; if (dn != 3) begin errors++; $display("FAIL reload_dones got=%0d exp=3", dn); end
        checks++; if (wraps !== 8'd3) begin errors++; $display("FAIL reload_wraps got=%0d exp=3", wraps); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL reload_state got=%0d exp=1", state); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_pause();
        int exp_c[4] = '{3, 4, 5, 0};
        term = 4'd5; reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL pause_pre got=%0d exp=2", count); end
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (count !== 4'd2 || state !== 2'b10 || done !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL pause_hold i=%0d count=%0d state=%0d done=%0d busy=%0d exp 2/2/0/1", i, count, state, done, busy);
            end
        end
        pause = 1'b0;
        tick();
        checks++; if (count !== 4'd2 || state !== 2'b01) begin errors++; $display("FAIL pause_resume count=%0d state=%0d exp 2/1", count, state); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (count !== exp_c[i][3:0] || done !== (i == 3)) begin
                errors++; $display("FAIL pause_after i=%0d count=%0d done=%0d exp %0d/%0d", i, count, done, exp_c[i], (i == 3));
            end
        end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL pause_final_state got=%0d exp=3", state); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_priority();
        start = 1'b1; stop = 1'b1; term = 4'd5;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if (state !== 2'b00 || count !== 4'd0) begin errors++; $display("FAIL prio_idle state=%0d count=%0d exp 0/0", state, count); end
        term = 4'd9; reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b1; term = 4'd2;
        tick();
        start = 1'b0;
        checks++; if (count !== 4'd1 || state !== 2'b01) begin errors++; $display("FAIL prio_start_ignored count=%0d state=%0d exp 1/1", count, state); end
        tick(); tick(); tick();
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL prio_term_ignored got=%0d exp=4", count); end
        pause = 1'b1;
        tick();
        checks++; if (state !== 2'b10 || count !== 4'd4) begin errors++; $display("FAIL prio_paused state=%0d count=%0d exp 2/4", state, count); end
        stop = 1'b1;
        tick();
        stop = 1'b0; pause = 1'b0;
        checks++; if (state !== 2'b00 || count !== 4'd0 || done !== 1'b0) begin
            errors++; $display("FAIL prio_stop_pause state=%0d count=%0d done=%0d exp 0/0/0", state, count, done);
        end
    endtask

    task automatic test_boundaries();
        int dn_bad = 0;
        term = 4'd0; reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done !== 1'b1 || count !== 4'd0 || wraps !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
                dn_bad++;
                if (dn_bad < 4) $display("FAIL term0_reload i=%0d done=%0d count=%0d wraps=%0d", i, done, count, wraps);
            end
        end
        checks++; if (dn_bad != 0) begin errors++; $display("FAIL term0_reload_total bad=%0d exp=0", dn_bad); end
        checks++; if (wraps !== 8'd255) begin errors++; $display("FAIL wraps_saturate got=%0d exp=255", wraps); end
        stop = 1'b1; tick(); stop = 1'b0;
        reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || state !== 2'b11) begin errors++; $display("FAIL term0_oneshot done=%0d state=%0d exp 1/3", done, state); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL term0_oneshot_once got=%0d exp=0", done); end
        term = 4'd15; reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (count !== 4'((i + 1) % 16) || done !== (i == 15)) begin
                errors++; $display("FAIL term15 i=%0d count=%0d done=%0d exp %0d/%0d", i, count, done, (i + 1) % 16, (i == 15));
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_async_reset();
        term = 4'd15; reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL areset_pre got=%0d exp=7", count); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || state !== 2'b00 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_immediate count=%0d state=%0d done=%0d busy=%0d exp 0/0/0/0", count, state, done, busy);
        end
        model_reset();
        #2;
        reset = 1'b1;
        tick();
        checks++; if (state !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL areset_after state=%0d done=%0d exp 0/0", state, done); end
    endtask

    task automatic test_random();
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 5) == 0);
            stop   = ($urandom_range(0, 24) == 0);
            pause  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) reload = 1'($urandom_range(0, 1));
            term   = 4'($urandom_range(0, 15));
            tick();
            checks++; if (count !== 4'(exp_count())) begin errors++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, exp_count()); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done i=%0d got=%0d exp=%0d", i, done, m_done); end
            checks++; if (state !== 2'(m_mode)) begin errors++; $display("FAIL rnd_state i=%0d got=%0d exp=%0d", i, state, m_mode); end
            checks++; if (busy !== (m_mode == 1 || m_mode == 2)) begin errors++; $display("FAIL rnd_busy i=%0d got=%0d", i, busy); end
            checks++; if (wraps !== 8'(exp_wraps())) begin errors++; $display("FAIL rnd_wraps i=%0d got=%0d exp=%0d", i, wraps, exp_wraps()); end
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_priority();
        test_boundaries();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
